// File: rtl/a23_io_pkg.sv
// Shared types and constants for the a23 host I/O sequencer.
package a23_io_pkg;

    localparam int WORD_W = 32;

    localparam int          CNT_W   = 32;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_LOAD_P = 3'd0,
        S_LOAD_G = 3'd1,
        S_LOAD_E = 3'd2,
        S_RUN    = 3'd3,
        S_UNLOAD = 3'd4,
        S_DONE   = 3'd5
    } seq_state_e;

    function automatic logic is_load(input seq_state_e s);
        return (s == S_LOAD_P) || (s == S_LOAD_G) || (s == S_LOAD_E);
    endfunction

    // Successor once the last word of a load phase is accepted.
    function automatic seq_state_e next_load_state(input seq_state_e s);
        case (s)
            S_LOAD_P: return S_LOAD_G;
            S_LOAD_G: return S_LOAD_E;
            default:  return S_RUN;
        endcase
    endfunction

endpackage

// File: rtl/a23_stream_unloader.sv
// Snapshot register plus valid/ready output stage that streams the
// captured words out in index order, flagging the last one.
module a23_stream_unloader
    import a23_io_pkg::*;
#(
    parameter int N_WORDS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture,
    input  logic [N_WORDS*WORD_W-1:0] o,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      unload_done
);

    localparam int IDX_W = $clog2(N_WORDS + 1);

    logic [N_WORDS*WORD_W-1:0] snap_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      active_q;
    logic                      valid_q;
    logic                      last_q;
    logic [WORD_W-1:0]         data_q;
    logic                      advance;

    // Output register refills when empty or when the held word is taken.
    assign advance     = active_q & (~valid_q | out_ready);
    assign unload_done = valid_q & out_ready & last_q;

    // Snapshot capture and output word sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q   <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else if (capture) begin
            snap_q   <= o;
            idx_q    <= '0;
            active_q <= 1'b1;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (unload_done) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else if (advance) begin
            // idx_q < N_WORDS here: after the last word is loaded the only
            // way forward is unload_done.
            valid_q <= 1'b1;
            data_q  <= snap_q[WORD_W*int'(idx_q) +: WORD_W];
            last_q  <= (idx_q == IDX_W'(N_WORDS - 1));
            idx_q   <= idx_q + IDX_W'(1);
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/a23_io_sequencer.sv
// Host-side load/run/unload sequencer around a23_gc_main.
// Optional build macro: A23_IO_CYCLE_COUNT_EN appends a saturating RUN-cycle
// count as an extra final output word.
//
// state    | meaning
// ---------+---------------------------------------------------
// LOAD_P   | streaming code words into p_init, core held in reset
// LOAD_G   | streaming garbler words into g_init
// LOAD_E   | streaming evaluator words into e_init
// RUN      | core released, waiting for terminate
// UNLOAD   | core back in reset, snapshot words streamed out
// DONE     | stream complete, idle until rst
module a23_io_sequencer
    import a23_io_pkg::*;
#(
    parameter int CODE_MEM_SIZE = 512,
    parameter int G_MEM_SIZE    = 64,
    parameter int E_MEM_SIZE    = 64,
    parameter int OUT_MEM_SIZE  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [WORD_W-1:0]               in_data,
    output logic                            in_ready,
    output logic [CODE_MEM_SIZE*WORD_W-1:0] p_init,
    output logic [G_MEM_SIZE*WORD_W-1:0]    g_init,
    output logic [E_MEM_SIZE*WORD_W-1:0]    e_init,
    output logic                            core_rst,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0]  o,
    input  logic                            terminate,
    output logic                            out_valid,
    output logic [WORD_W-1:0]               out_data,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            done
);

    localparam int MAX_PG = (CODE_MEM_SIZE > G_MEM_SIZE) ? CODE_MEM_SIZE : G_MEM_SIZE;
    localparam int MAX_SZ = (MAX_PG > E_MEM_SIZE) ? MAX_PG : E_MEM_SIZE;
    localparam int IDX_W  = (MAX_SZ > 1) ? $clog2(MAX_SZ) : 1;

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_last;
    logic             in_ready_q, core_rst_q, done_q;
    logic             accept, capture, unload_done;

    logic [CODE_MEM_SIZE*WORD_W-1:0] p_q;
    logic [G_MEM_SIZE*WORD_W-1:0]    g_q;
    logic [E_MEM_SIZE*WORD_W-1:0]    e_q;

    assign accept  = in_valid & in_ready_q;
    assign capture = (state_q == S_RUN) & terminate;

`ifdef A23_IO_CYCLE_COUNT_EN
    localparam int N_OUT = OUT_MEM_SIZE + 1;
    logic [CNT_W-1:0]        cnt_q;
    logic [N_OUT*WORD_W-1:0] cap_bus;

    // Saturating count of RUN cycles that did not see terminate.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == S_RUN) && !terminate && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cap_bus = {cnt_q, o};
`else
    localparam int N_OUT = OUT_MEM_SIZE;
    logic [N_OUT*WORD_W-1:0] cap_bus;

    assign cap_bus = o;
`endif

    // Next state and load index; index restarts on every phase change.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        idx_last = 1'b0;
        case (state_q)
            S_LOAD_P: idx_last = (idx_q == IDX_W'(CODE_MEM_SIZE - 1));
            S_LOAD_G: idx_last = (idx_q == IDX_W'(G_MEM_SIZE - 1));
            S_LOAD_E: idx_last = (idx_q == IDX_W'(E_MEM_SIZE - 1));
            default:  idx_last = 1'b0;
        endcase
        if (accept) begin
            if (idx_last) begin
                idx_d   = '0;
                state_d = next_load_state(state_q);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        if (capture) begin
            state_d = S_UNLOAD;
        end
        if ((state_q == S_UNLOAD) && unload_done) begin
            state_d = S_DONE;
        end
    end

    // State register; handshake/status outputs are registered from state_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD_P;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_ready_q <= is_load(state_d);
            core_rst_q <= (state_d != S_RUN);
            done_q     <= (state_d == S_DONE);
        end
    end

    // Accepted host words land in the bus of the current load phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            g_q <= '0;
            e_q <= '0;
        end else if (accept) begin
            case (state_q)
                S_LOAD_P: p_q[WORD_W*int'(idx_q) +: WORD_W] <= in_data;
                S_LOAD_G: g_q[WORD_W*int'(idx_q) +: WORD_W] <= in_data;
                S_LOAD_E: e_q[WORD_W*int'(idx_q) +: WORD_W] <= in_data;
                default:  ;
            endcase
        end
    end

    a23_stream_unloader #(
        .N_WORDS (N_OUT)
    ) u_unloader (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .o           (cap_bus),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .unload_done (unload_done)
    );

    assign in_ready = in_ready_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
    assign p_init   = p_q;
    assign g_init   = g_q;
    assign e_init   = e_q;

endmodule

// File: tb/tb_a23_io_sequencer.sv
// Self-checking bench for a23_io_sequencer (CODE=4, G=2, E=2, OUT=2).
module tb_a23_io_sequencer;

`ifdef A23_IO_CYCLE_COUNT_EN
    localparam int NW = 3;
`else
    localparam int NW = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready;
    logic [127:0] p_init;
    logic [63:0]  g_init;
    logic [63:0]  e_init;
    logic         core_rst;
    logic [63:0]  o = '0;
    logic         terminate = 1'b0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic         done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    a23_io_sequencer #(
        .CODE_MEM_SIZE (4),
        .G_MEM_SIZE    (2),
        .E_MEM_SIZE    (2),
        .OUT_MEM_SIZE  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .p_init    (p_init),
        .g_init    (g_init),
        .e_init    (e_init),
        .core_rst  (core_rst),
        .o         (o),
        .terminate (terminate),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (done)
    );

    typedef struct {
        logic [7:0][31:0] words;
        logic [7:0]       vpat;
        logic [63:0]      o_val;
        int               run_len;
        logic [7:0]       rpat;
        logic [127:0]     exp_p;
        logic [63:0]      exp_g;
        logic [63:0]      exp_e;
        logic [2:0][31:0] exp_s;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; terminate = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_p_init", p_init, 0);
        chk("rst_g_init", g_init, 0);
        chk("rst_e_init", e_init, 0);
        chk("rst_outs", {out_valid, out_last, done, out_data}, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        tick();
        chk("in_ready_after_rst", in_ready, 1);
    endtask

    // Host side: in LOAD every in_valid cycle is accepted in order.
    task automatic do_load(input logic [7:0][31:0] words, input logic [7:0] vpat, input int lim);
        int acc = 0;
        for (int cyc = 0; cyc < 200 && acc < lim; cyc++) begin
            in_valid  = vpat[cyc % 8];
            in_data   = in_valid ? words[acc] : $urandom;
            terminate = 1'($urandom_range(0, 1));
            tick();
            if (in_valid) acc++;
            chk("load_in_ready", in_ready, (acc < 8) ? 1 : 0);
            chk("load_core_rst", core_rst, (acc < 8) ? 1 : 0);
        end
        chk("load_budget", acc, lim);
        in_valid = 1'b0; terminate = 1'b0;
    endtask

    task automatic do_run(input logic [63:0] o_val, input int run_len);
        o = o_val; terminate = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < run_len; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick();
            chk("run_core_rst", core_rst, 0);
            chk("run_no_out", out_valid, 0);
        end
        in_valid = 1'b0;
        terminate = 1'b1;
        tick();
        terminate = 1'b0;
        o = {$urandom, $urandom};
        chk("term_latency", out_valid, 0);
        chk("unload_core_rst", core_rst, 1);
    endtask

    task automatic do_unload(input logic [7:0] rpat, input logic [2:0][31:0] exp_s);
        int n = 0;
        logic held = 1'b0;
        logic [31:0] hdata = '0;
        for (int cyc = 0; cyc < 100 && n < NW; cyc++) begin
            tick();
            if (held) chk("stall_stable", {out_valid, out_data}, {1'b1, hdata});
            chk("done_early", done, 0);
            out_ready = rpat[cyc % 8];
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("out_data", out_data, exp_s[n]);
                    chk("out_last", out_last, (n == NW - 1) ? 1 : 0);
                    n++;
                end else begin
                    held = 1'b1;
                    hdata = out_data;
                end
            end
        end
        chk("unload_budget", n, NW);
        tick();
        chk("done_set", {done, out_valid, out_last}, 3'b100);
        out_ready = 1'b0;
    endtask

    task automatic run_full(input vec_t v);
        do_reset();
        do_load(v.words, v.vpat, 8);
        chk("p_init", p_init, v.exp_p);
        chk("g_init", g_init, v.exp_g);
        chk("e_init", e_init, v.exp_e);
        do_run(v.o_val, v.run_len);
        chk("hold_p_init", p_init, v.exp_p);
        do_unload(v.rpat, v.exp_s);
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; terminate = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0; terminate = 1'b0;
        chk("done_hold", {done, in_ready, out_valid, core_rst}, 4'b1001);
        chk("done_p_init", p_init, v.exp_p);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        tbl[0].words = {32'hB1, 32'hB0, 32'hA1, 32'hA0, 32'h13, 32'h12, 32'h11, 32'h10};
        tbl[0].vpat  = 8'hFF;
        tbl[0].o_val = {32'hDEAD0001, 32'hBEEF0000};
        tbl[0].run_len = 5;
        tbl[0].rpat  = 8'hFF;
        tbl[0].exp_p = 128'h00000013_00000012_00000011_00000010;
        tbl[0].exp_g = 64'h000000A1_000000A0;
        tbl[0].exp_e = 64'h000000B1_000000B0;
        tbl[0].exp_s = {32'd5, 32'hDEAD0001, 32'hBEEF0000};
        tbl[1] = tbl[0];
        tbl[1].vpat  = 8'b0101_0101;
        tbl[2] = tbl[0];
        tbl[2].o_val = {32'h12345678, 32'h9ABCDEF0};
        tbl[2].run_len = 0;
        tbl[2].rpat  = 8'b1111_0001;
        tbl[2].exp_s = {32'd0, 32'h12345678, 32'h9ABCDEF0};

        for (int i = 0; i < 3; i++) run_full(tbl[i]);

        // Randomized scenarios against a spec-level model.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) rv.words[k] = $urandom;
            rv.vpat    = 8'($urandom) | 8'h01;
            rv.rpat    = 8'($urandom) | 8'h01;
            rv.o_val   = {$urandom, $urandom};
            rv.run_len = $urandom_range(0, 12);
            for (int k = 0; k < 4; k++) rv.exp_p[32*k +: 32] = rv.words[k];
            for (int k = 0; k < 2; k++) rv.exp_g[32*k +: 32] = rv.words[4 + k];
            for (int k = 0; k < 2; k++) rv.exp_e[32*k +: 32] = rv.words[6 + k];
            for (int k = 0; k < 2; k++) rv.exp_s[k] = rv.o_val[32*k +: 32];
            rv.exp_s[2] = 32'(rv.run_len);
            run_full(rv);
        end

        // Reset during LOAD_G, then a clean reload.
        do_reset();
        do_load(tbl[0].words, 8'hFF, 5);
        chk("midg_p_loaded", p_init, tbl[0].exp_p);
        rst = 1'b1;
        tick();
        chk("midg_buses", {p_init, g_init, e_init}, 0);
        chk("midg_ctl", {core_rst, in_ready, out_valid}, 3'b100);
        rst = 1'b0;
        run_full(tbl[0]);

        // Reset during UNLOAD, then a clean reload.
        do_reset();
        do_load(tbl[0].words, 8'hFF, 8);
        do_run(tbl[0].o_val, 5);
        tick();
        chk("midu_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("midu_buses", {p_init, g_init, e_init}, 0);
        chk("midu_ctl", {core_rst, out_valid, done, in_ready}, 4'b1000);
        rst = 1'b0;
        run_full(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/a23_io_sequencer.md
# a23_io_sequencer

Host-side sequencing stage wrapped around `a23_gc_main`. It streams program, garbler and evaluator words into the core's flat `p_init`/`g_init`/`e_init` buses and holds the core in reset while loading. It then releases the core and counts cycles until `terminate`. Finally it snapshots the core's `o` bus and streams the output words back to the host over a valid/ready port.

## Interface
- `CODE_MEM_SIZE`, default 512, code words streamed into `p_init` (≥1).
- `G_MEM_SIZE`, default 64, garbler words streamed into `g_init` (≥1).
- `E_MEM_SIZE`, default 64, evaluator words streamed into `e_init` (≥1).
- `OUT_MEM_SIZE`, default 64, words captured from `o` and streamed out (≥1).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: host word valid.
- `in_data` in 32: host word.
- `in_ready` out 1: sequencer accepts `in_data`.
- `p_init` out CODE_MEM_SIZE*32: to core.
- `g_init` out G_MEM_SIZE*32: to core.
- `e_init` out E_MEM_SIZE*32: to core.
- `core_rst` out 1: drives core `rst`.
- `o` in OUT_MEM_SIZE*32: from core.
- `terminate` in 1: from core.
- `out_valid` out 1: output word valid.
- `out_data` out 32: output word.
- `out_last` out 1: final word of output stream.
- `out_ready` in 1: host accepts output word.
- `done` out 1: unload complete.

## Operation
- States: LOAD_P → LOAD_G → LOAD_E → RUN → UNLOAD → DONE.
- Reset value of every output: `in_ready`=0, `core_rst`=1, all init buses 0, `out_valid`/`out_last`/`done`=0, `out_data`=0.
- **Load:**
  - `in_ready`=1 in the LOAD states only.
  - A word is accepted on a clk edge with `in_valid & in_ready`.
  - Word index k (0-based within the current state) lands in bits [32k+31:32k] of that state's bus.
  - The index advances per accepted word. It resets to 0 on each state change.
  - On acceptance of word SIZE-1, the FSM moves to the next state.
- **Run:**
  - `core_rst`=0 only in RUN.
  - `terminate` is ignored in every other state.
  - In RUN, the first cycle with `terminate`=1 captures all of `o` into a snapshot register and moves to UNLOAD.
  - Init buses hold their loaded values through RUN, UNLOAD and DONE.
- **Unload:**
  - `core_rst`=1 again.
  - Snapshot words 0..OUT_MEM_SIZE-1 are presented in order.
  - `out_data`, `out_valid` and `out_last` are registered. They stay stable while `out_valid & ~out_ready`.
  - After the final transfer, the FSM enters DONE.
- **Done:** `done`=1, `out_valid`=0, `in_ready`=0. The block stays in DONE until `rst`.
- **Reset mid-operation:** `rst` in any state returns to LOAD_P with index 0. Init buses and the snapshot are cleared. All outputs return to reset values on the next edge.
- Extra `in_valid` pulses outside the LOAD states are ignored (`in_ready`=0).

## Timing
- The first `in_ready`=1 appears in the cycle after `rst` falls.
- Load takes (CODE+G+E) accepted words, with no throughput bubble: 1 word/cycle when `in_valid` is held.
- `core_rst` falls on the edge that accepts the final E word.
- Terminate to first `out_valid` is 1 cycle. `terminate` is sampled at edge t; `out_valid`=1 after edge t+1.
- Output throughput is 1 word/cycle with `out_ready` held.
- `out_last`=1 only with the final word.
- `done` rises on the edge that completes the final output transfer.

## Configuration
- `A23_IO_CYCLE_COUNT_EN`:
  - **Defined:** a 32-bit run counter is added.
    - It clears on `rst` and increments every RUN cycle with `terminate`=0.
    - It saturates at 0xFFFFFFFF.
    - Its value is appended as one extra output word after snapshot word OUT_MEM_SIZE-1, and `out_last` moves to that word.
  - **Undefined:** no counter is built. The stream is exactly OUT_MEM_SIZE words.

## Structure
- **Package `a23_io_pkg`:**
  - FSM state enum.
  - Word width constant (32).
  - Cycle-counter width and saturation constant.
- **Sub-module `a23_stream_unloader`:**
  - Owns the snapshot register, output index, valid/ready holding register and `out_last` generation.
  - Takes `capture` and `o` as inputs and returns `unload_done`.

## Test plan
Bench parameters: CODE=4, G=2, E=2, OUT=2.
- Stream 0x10..0x13, 0xA0, 0xA1, 0xB0, 0xB1 with `in_valid` held → `p_init`=0x00000013_00000012_00000011_00000010, `g_init`=0x000000A1_000000A0, `e_init`=0x000000B1_000000B0; `core_rst` falls on the 8th accept edge.
- Toggle `in_valid` every other cycle → same bus contents; `in_ready` stays 1 and the index advances only on accepts.
- In RUN, set `o`={0xDEAD0001, 0xBEEF0000} and raise `terminate` at RUN cycle 5 → words 0xBEEF0000 then 0xDEAD0001; `out_last` on the second (macro off).
- Same as above with `A23_IO_CYCLE_COUNT_EN` defined → 3 words, third = 5, `out_last` on the third.
- Hold `out_ready`=0 for 3 cycles mid-unload → `out_data`/`out_valid` stable; no word lost or duplicated; `done` after the last transfer.
- Assert `rst` during LOAD_G and again during UNLOAD → buses return to 0, `core_rst`=1, `out_valid`=0; a reload then reproduces scenario 1 results.
